// File: rtl/display_pkg.sv
// Shared timing constants and state type for the LED nibble display path.
package display_pkg;

  localparam int NIBBLE_CYCLES = 6_000_000;
  localparam int FRAME_CYCLES  = 4 * NIBBLE_CYCLES;

  typedef enum logic {
    IDLE,
    DWELL
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head word and occupancy-based full/empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_level;
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rdNext;

  assign o_full   = (r_level == (AW+1)'(DEPTH));
  assign o_empty  = (r_level == '0);
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && !o_empty;
  assign w_rdNext = r_rdPtr + AW'(w_pop);

  assign o_head  = r_head;
  assign o_level = r_level;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // The head register tracks whatever will sit at the read pointer after this edge,
  // bypassing the incoming word when it lands directly in the head slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_head  <= '0;
    end else begin
      r_wrPtr <= r_wrPtr + AW'(w_push);
      r_rdPtr <= w_rdNext;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push && (r_wrPtr == w_rdNext)) begin
        r_head <= i_data;
      end else begin
        r_head <= r_mem[w_rdNext];
      end
    end
  end

endmodule

// File: rtl/display_value_queue.sv
// Buffers 16-bit values and presents each to the nibble display for a fixed dwell time.
module display_value_queue
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = FRAME_CYCLES,
  parameter int DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [15:0]            in_data,
  output logic                   in_ready,
  output logic [15:0]            value,
  output logic                   value_new,
  output logic [$clog2(DEPTH):0] level
);

  localparam int            CW       = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(DWELL_CYCLES - 1);

  state_t      r_state;
  state_t      w_stateNext;
  logic [CW-1:0] r_count;
  logic [15:0] r_value;
  logic        r_valueNew;

  logic [15:0] w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_terminal;

  sync_fifo #(
    .WIDTH(16),
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_push (in_valid),
    .i_data (in_data),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_level(level),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign in_ready   = !w_full;
  assign value      = r_value;
  assign value_new  = r_valueNew;
  assign w_terminal = (r_count == TERMINAL);

  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_stateNext = DWELL;
        end
      end
      DWELL: begin
        if (w_terminal) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Each pop restarts the dwell; the counter parks at zero whenever nothing is dwelling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value    <= '0;
      r_valueNew <= 1'b0;
      r_count    <= '0;
    end else begin
      r_valueNew <= w_pop;
      if (w_pop) begin
        r_value <= w_head;
        r_count <= '0;
      end else if ((r_state == DWELL) && !w_terminal) begin
        r_count <= r_count + 1'b1;
      end else begin
        r_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_display_value_queue.sv
// Scoreboard bench: accepted pushes are queued with their accept edge, the monitor predicts load times.
module tb_display_value_queue;

  localparam int DWELL = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [15:0] data;
    int          acceptEdge;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [15:0] inData;
  logic        inReady;
  logic [15:0] value;
  logic        valueNew;
  logic [2:0]  level;

  entry_t      expQ[$];
  int          cycleCount = 0;
  int          lastLoad   = -1000;
  logic [15:0] lastValue  = '0;
  int          testsRun   = 0;
  int          testsFailed = 0;

  display_value_queue #(
    .DWELL_CYCLES(DWELL),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_data  (inData),
    .in_ready (inReady),
    .value    (value),
    .value_new(valueNew),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at edge %0d: got %h, want %h", name, cycleCount, actual, expected);
    end
  endtask

  // A value queued behind others (or accepted while idle) appears one edge after its accept,
  // but never before the previous value has had its full dwell.
  always @(negedge clk) begin : monitor
    int due;
    bit loadDue;
    if (rst) begin
      expQ.delete();
      lastLoad  = -1000;
      lastValue = '0;
    end else begin
      loadDue = 1'b0;
      if (expQ.size() > 0) begin
        due = expQ[0].acceptEdge + 1;
        if (lastLoad + DWELL > due) due = lastLoad + DWELL;
        if (due <= cycleCount) loadDue = 1'b1;
      end
      if (loadDue) begin
        checkOutput("value_new on load", 32'(valueNew), 32'd1);
        checkOutput("loaded value", 32'(value), 32'(expQ[0].data));
        lastValue = expQ[0].data;
        lastLoad  = due;
        void'(expQ.pop_front());
      end else begin
        checkOutput("value_new quiet", 32'(valueNew), 32'd0);
        checkOutput("value held", 32'(value), 32'(lastValue));
      end
      checkOutput("level", 32'(level), 32'(expQ.size()));
      checkOutput("in_ready", 32'(inReady), 32'(expQ.size() != DEPTH));
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; holds the word until accepted, logs the accepting edge.
  task automatic applyStimulus(input logic [15:0] data);
    bit accepted = 1'b0;
    inValid = 1'b1;
    inData  = data;
    for (int i = 0; i < 200 && !accepted; i++) begin
      #6;
      if (inReady) begin
        expQ.push_back('{data, cycleCount + 1});
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    if (!accepted) checkOutput("push accepted", 32'd0, 32'd1);
  endtask

  task automatic resetAndCheck();
    #1;
    rst = 1'b1;
    #1;
    checkOutput("reset value", 32'(value), 32'h0000);
    checkOutput("reset in_ready", 32'(inReady), 32'd1);
    checkOutput("reset level", 32'(level), 32'd0);
    checkOutput("reset value_new", 32'(valueNew), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitDrained(input int budget);
    for (int i = 0; i < budget && expQ.size() != 0; i++) idleCycles(1);
    checkOutput("queue drained", 32'(expQ.size()), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int loadEdge;
    bit seen;
    rst     = 1'b1;
    inValid = 1'b0;
    inData  = '0;
    idleCycles(3);
    rst = 1'b0;
    idleCycles(2);

    resetAndCheck();
    idleCycles(3);

    applyStimulus(16'hA5C3);
    idleCycles(100);

    applyStimulus(16'h1111);
    applyStimulus(16'h2222);
    applyStimulus(16'h3333);
    idleCycles(40);

    applyStimulus(16'h0F0F);
    idleCycles(2);
    for (int i = 0; i < 6; i++) applyStimulus(16'h4000 + 16'(i));
    waitDrained(200);
    idleCycles(12);

    applyStimulus(16'hBEEF);
    applyStimulus(16'hCAFE);
    applyStimulus(16'hD00D);
    idleCycles(1);
    resetAndCheck();
    idleCycles(30);

    seen = 1'b0;
    applyStimulus(16'h7E57);
    for (int i = 0; i < 50 && !seen; i++) begin
      if (value == 16'h7E57) seen = 1'b1;
      else idleCycles(1);
    end
    checkOutput("terminal-case first load", 32'(seen), 32'd1);
    loadEdge = cycleCount;
    while (cycleCount < loadEdge + DWELL - 1) idleCycles(1);
    applyStimulus(16'h9A9A);
    idleCycles(20);

    for (int i = 0; i < 60; i++) begin
      idleCycles($urandom_range(0, 12));
      applyStimulus(16'($urandom));
    end
    waitDrained(400);
    idleCycles(12);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
